// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        REDIRECT
    } ifu_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ifu_entry_t;

    localparam int          QUEUE_DEPTH = 2;
    localparam int          PTR_W       = $clog2(QUEUE_DEPTH);
    localparam int          CNT_W       = $clog2(QUEUE_DEPTH + 1);
    localparam logic [31:0] PC_STEP     = 32'd4;

endpackage

// File: rtl/ifu_queue.sv
// Two-entry {pc,instr} FIFO between the memory response and the IF/ID register.
module ifu_queue
    import ifu_pkg::*;
(
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       clear,
    input  logic       push,
    input  ifu_entry_t push_data,
    input  logic       pop,
    output ifu_entry_t head,
    output logic       full,
    output logic       empty
);

    ifu_entry_t             mem [QUEUE_DEPTH];
    logic [PTR_W-1:0]       rd_ptr;
    logic [PTR_W-1:0]       wr_ptr;
    logic [CNT_W-1:0]       count;
    logic                   do_push;
    logic                   do_pop;

    assign full    = (count == CNT_W'(QUEUE_DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot a push into a full queue needs.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge Clk) begin
        if (!Rst_n || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge Clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues imem reads, buffers responses, feeds IF/ID.
// Optional bubble counter enabled by defining IFU_PERF_CNT_EN.
module instr_fetch_unit
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction_out,
    output logic [31:0] pc_out,
    output logic        flush,
    output logic [31:0] bubble_count
);

    ifu_state_e  state_q;
    ifu_state_e  state_d;
    logic [31:0] fpc;
    logic        req_vld_p1;
    logic [31:0] req_pc_p1;

    logic        q_push;
    logic        q_pop;
    logic        q_full;
    logic        q_empty;
    ifu_entry_t  q_head;
    ifu_entry_t  resp_entry;

    logic        load_head;
    logic        load_resp;
    logic        load_nop;

    ifu_queue u_queue (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .clear     (branch_taken),
        .push      (q_push),
        .push_data (resp_entry),
        .pop       (q_pop),
        .head      (q_head),
        .full      (q_full),
        .empty     (q_empty)
    );

    always_comb begin
        state_d = state_q;
        if (branch_taken) begin
            state_d = REDIRECT;
        end else begin
            unique case (state_q)
                IDLE:     state_d = FETCH;
                FETCH:    state_d = FETCH;
                REDIRECT: state_d = FETCH;
                default:  state_d = IDLE;
            endcase
        end
    end

    // Occupancy plus in-flight below two: empty queue, or one slot and nothing in flight.
    always_comb begin
        imem_req         = (state_q == FETCH) && !branch_taken &&
                           (q_empty || (!q_full && !req_vld_p1));
        imem_addr        = fpc;
        resp_entry.pc    = req_pc_p1;
        resp_entry.instr = imem_rdata;
        load_head        = 1'b0;
        load_resp        = 1'b0;
        load_nop         = 1'b0;
        q_push           = 1'b0;
        q_pop            = 1'b0;
        if (branch_taken) begin
            load_nop = 1'b1;
        end else if (!stall) begin
            if (!q_empty) begin
                load_head = 1'b1;
                q_pop     = 1'b1;
                q_push    = req_vld_p1;
            end else if (req_vld_p1) begin
                // Empty queue: the response passes straight through to IF/ID.
                load_resp = 1'b1;
            end else begin
                load_nop  = 1'b1;
            end
        end else begin
            q_push = req_vld_p1;
        end
    end

    // Stage p0 -> p1: request issue, in-flight tracking and IF/ID register
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q         <= IDLE;
            fpc             <= RESET_PC;
            req_vld_p1      <= 1'b0;
            flush           <= 1'b0;
            instruction_out <= NOP_WORD;
            pc_out          <= RESET_PC;
        end else begin
            state_q    <= state_d;
            flush      <= branch_taken;
            req_vld_p1 <= imem_req;
            if (branch_taken) begin
                fpc <= branch_target;
            end else if (imem_req) begin
                fpc <= fpc + PC_STEP;
            end
            if (load_head) begin
                instruction_out <= q_head.instr;
                pc_out          <= q_head.pc;
            end else if (load_resp) begin
                instruction_out <= imem_rdata;
                pc_out          <= req_pc_p1;
            end else if (load_nop) begin
                instruction_out <= NOP_WORD;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (imem_req) req_pc_p1 <= fpc;
    end

`ifdef IFU_PERF_CNT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic [31:0] bubble_q;

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            bubble_q <= '0;
        end else if (load_nop) begin
            bubble_q <= sat_inc(bubble_q);
        end
    end

    assign bubble_count = bubble_q;
`else
    assign bubble_count = '0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed + random bench for instr_fetch_unit against a queue-level reference model.
module tb_instr_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] instruction_out;
    logic [31:0] pc_out;
    logic        flush;
    logic [31:0] bubble_count;

    int checks   = 0;
    int failures = 0;

    instr_fetch_unit #(.RESET_PC(RST_PC), .NOP_WORD(NOP)) dut (
        .Clk             (Clk),
        .Rst_n           (Rst_n),
        .stall           (stall),
        .branch_taken    (branch_taken),
        .branch_target   (branch_target),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_rdata      (imem_rdata),
        .instruction_out (instruction_out),
        .pc_out          (pc_out),
        .flush           (flush),
        .bubble_count    (bubble_count)
    );

    always #5 Clk = ~Clk;

    // Memory: returns addr ^ key one cycle after a request, junk otherwise.
    logic [31:0] mem_key = 32'h0;
    always @(posedge Clk) imem_rdata <= imem_req ? (imem_addr ^ mem_key) : $urandom();

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        m_q[$];
    bit          m_fly;
    logic [31:0] m_fly_pc, m_fly_data;
    logic [31:0] m_fpc;
    int          m_wait;
    logic [31:0] m_out, m_pc;
    logic        m_flush;
    logic [31:0] m_bub;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] bump(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    task automatic step(input logic rn, input logic s, input logic b, input logic [31:0] t);
        logic        req_exp;
        logic [31:0] fdata;
        ent_t        e;
        Rst_n = rn; stall = s; branch_taken = b; branch_target = t;
        req_exp = rn && (m_wait == 0) && !b && ((m_q.size() + (m_fly ? 1 : 0)) < 2);
        @(negedge Clk);
        if (rn) begin
            chk("imem_req", 32'(imem_req), 32'(req_exp));
            if (req_exp) chk("imem_addr", imem_addr, m_fpc);
        end
        @(posedge Clk);
        if (!rn) begin
            m_q.delete(); m_fly = 0; m_fpc = RST_PC; m_wait = 1;
            m_out = NOP; m_pc = RST_PC; m_flush = 0; m_bub = 0;
        end else begin
            fdata = m_fpc ^ mem_key;
            if (b) begin
                m_q.delete(); m_out = NOP; m_flush = 1; m_fpc = t; m_wait = 1;
                m_bub = bump(m_bub);
            end else begin
                m_flush = 0;
                if (m_fly) m_q.push_back('{pc: m_fly_pc, instr: m_fly_data});
                if (!s) begin
                    if (m_q.size() > 0) begin
                        e = m_q.pop_front(); m_out = e.instr; m_pc = e.pc;
                    end else begin
                        m_out = NOP; m_bub = bump(m_bub);
                    end
                end
                if (m_wait > 0) m_wait--;
            end
            if (req_exp) begin
                m_fly_pc = m_fpc; m_fly_data = fdata; m_fpc = m_fpc + 32'd4;
            end
            m_fly = req_exp;
        end
        #1;
        chk("instruction_out", instruction_out, m_out);
        chk("pc_out", pc_out, m_pc);
        chk("flush", 32'(flush), 32'(m_flush));
`ifdef IFU_PERF_CNT_EN
        chk("bubble_count", bubble_count, m_bub);
`else
        chk("bubble_count", bubble_count, 32'h0);
`endif
    endtask

    initial begin
        logic [31:0] tr;
        logic        rr, sr, br;
        Rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
        m_fly = 0; m_wait = 1; m_fpc = RST_PC; m_bub = 0;

        // Reset, then address-as-data streaming
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("first_instr", instruction_out, 32'h0);
        chk("first_pc", pc_out, 32'h0);
        step(1, 0, 0, 0);
        chk("second_instr", instruction_out, 32'h4);
        for (int i = 0; i < 6; i++) step(1, 0, 0, 0);

        // Four-cycle stall in steady state
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0);
        chk("stall_no_req", 32'(imem_req), 32'h0);
        for (int i = 0; i < 6; i++) step(1, 0, 0, 0);

        // Redirect with a request in flight
        step(1, 0, 1, 32'h100);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("redirect_pc", pc_out, 32'h100);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0);

        // Redirect and stall in the same cycle, then back-to-back redirects
        step(1, 1, 0, 0);
        step(1, 1, 1, 32'h200);
        step(1, 0, 1, 32'h300);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0);

        // Fill the queue, then reset mid-stream
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0);
        step(0, 1, 0, 0);
        chk("rst_instr", instruction_out, NOP);
        chk("rst_pc", pc_out, RST_PC);
        for (int i = 0; i < 6; i++) step(1, 0, 0, 0);

        // Redirect near the top of the address space to exercise wrap
        mem_key = 32'h5A5A_0000;
        step(1, 0, 1, 32'hFFFF_FFF8);
        for (int i = 0; i < 8; i++) step(1, 0, 0, 0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            if (i % 50 == 0) mem_key = $urandom();
            tr = $urandom(); tr[1:0] = 2'b00;
            rr = ($urandom_range(99) != 0);
            sr = ($urandom_range(9) < 3);
            br = ($urandom_range(19) == 0);
            step(rr, sr, br, tr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
